// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard receive buffer: register map,
// status/control bit positions and the STATUS register layout.
package kbd_pkg;

    localparam int KBD_DEPTH = 8;
    localparam int KBD_AW    = 3;

    // register addresses
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    // status / control bit positions
    localparam int ST_OVF    = 4;
    localparam int ST_PERR   = 5;
    localparam int ST_IEN    = 6;
    localparam int ST_NE     = 7;
    localparam int CTL_FLUSH = 0;

    // STATUS register image, MSB first so the packed layout matches ST_*
    typedef struct packed {
        logic       ne;
        logic       ien;
        logic       perr;
        logic       ovf;
        logic [3:0] count;
    } status_t;

    // odd parity: data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/kbd_rx_fifo_sync2.sv
// Two-flop synchroniser with a selectable reset value, for single-bit
// levels crossing from in_clk into clk.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // two-stage capture; both stages come out of reset at RST_VAL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kbd_rx_fifo.sv
// PS/2 receive buffer: synchronises the receiver's frame-done level,
// checks odd parity, queues good scancodes in a small FIFO and exposes a
// DATA / STATUS-CTRL register pair with a level interrupt to the CPU.
module kbd_rx_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = KBD_DEPTH,
    parameter int AW    = KBD_AW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_parity,
    input  logic       rx_done,
    input  logic       cs,
    input  logic       rd,
    input  logic       wr,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    // frame-done crossing
    logic done_s;
    logic done_h;
    logic push_evt;
    logic frame_ok;

    // CPU strobe edges
    logic rd_sel, rd_q, pop_evt;
    logic wr_sel, wr_q, ctl_evt;

    // FIFO state
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          ovf, perr, ien;

    // per-cycle decisions
    logic full, empty;
    logic flush, pop_ok, push_ok, ovf_set, perr_set;
    logic ovf_clr, perr_clr;
    status_t stat;

    // din bits with no function in CTRL
    logic unused_din;
    assign unused_din = ^{din[7], din[3:1]};

    // history and synchroniser reset high so a done level held through
    // reset release is not mistaken for a new frame
    sync2 #(.RST_VAL(1'b1)) u_done_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_done),
        .q     (done_s)
    );

    // history flop for rising-edge detection of the synchronised done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) done_h <= 1'b1;
        else        done_h <= done_s;
    end

    assign push_evt = done_s & ~done_h;
    assign frame_ok = odd_parity_ok(rx_data, rx_parity);

    assign rd_sel  = cs & rd & (addr == ADDR_DATA);
    assign wr_sel  = cs & wr & (addr == ADDR_STAT);
    assign pop_evt = rd_q & ~rd_sel;   // pop when the read strobe ends
    assign ctl_evt = wr_sel & ~wr_q;   // control acts once per write strobe

    // registered strobes for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= rd_sel;
            wr_q <= wr_sel;
        end
    end

    // arbitration between flush, pop and push for this cycle
    always_comb begin
        empty    = (count == '0);
        full     = (count == (AW+1)'(DEPTH));
        flush    = ctl_evt & din[CTL_FLUSH];
        pop_ok   = pop_evt & ~empty & ~flush;
        // a pop in the same cycle frees a slot before the push lands
        push_ok  = push_evt & frame_ok & ~flush & (~full | pop_ok);
        ovf_set  = push_evt & frame_ok & ~flush & full & ~pop_ok;
        perr_set = push_evt & ~frame_ok;
        ovf_clr  = ctl_evt & din[ST_OVF];
        perr_clr = ctl_evt & din[ST_PERR];
    end

    // pointers, occupancy, sticky flags and interrupt enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            perr  <= 1'b0;
            ien   <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push_ok) wptr <= wptr + AW'(1);
                if (pop_ok)  rptr <= rptr + AW'(1);
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
            // a new event in the same cycle as a clear wins
            ovf  <= ovf_set  | (ovf  & ~ovf_clr);
            perr <= perr_set | (perr & ~perr_clr);
            if (ctl_evt) ien <= din[ST_IEN];
        end
    end

    // storage write; contents need no reset since reads are gated by count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= rx_data;
    end

    // level interrupt from registered enable and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= ien & ~empty;
    end

    // read mux: STATUS image or FIFO head (zero when empty)
    always_comb begin
        stat.ne    = ~empty;
        stat.ien   = ien;
        stat.perr  = perr;
        stat.ovf   = ovf;
        stat.count = 4'(count);
        dout       = 8'h00;
        if (addr == ADDR_STAT) dout = stat;
        else if (!empty)       dout = mem[rptr];
    end

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Self-checking bench for kbd_rx_fifo: a queue-based model of the buffer
// is compared against irq every cycle and against dout whenever a read
// is in progress; directed scenarios add hand-computed expectations.
module tb_kbd_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_parity = 1'b0;
    logic       rx_done = 1'b1;
    logic       cs = 1'b0, rd = 1'b0, wr = 1'b0, addr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    kbd_rx_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_parity (rx_parity),
        .rx_done   (rx_done),
        .cs        (cs),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .irq       (irq)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned mq[$];
    bit m_ovf, m_perr, m_ien, m_irq;
    bit d1, d2, d3;        // rx_done as seen at the last three edges
    bit m_rdp, m_wrp;      // strobe levels at the previous edge

    always @(posedge clk or negedge reset) begin
        bit push, pop, ctl, fl, good, rs, ws;
        if (!reset) begin
            mq.delete();
            m_ovf = 0; m_perr = 0; m_ien = 0; m_irq = 0;
            d1 = 1; d2 = 1; d3 = 1;
            m_rdp = 0; m_wrp = 0;
        end else begin
            // a frame is pushed 3 edges after rx_done is first seen high
            push = d2 & ~d3;
            d3 = d2; d2 = d1; d1 = rx_done;
            good = ^{rx_data, rx_parity};
            rs = cs & rd & ~addr;
            pop = m_rdp & ~rs;
            m_rdp = rs;
            ws = cs & wr & addr;
            ctl = ws & ~m_wrp;
            m_wrp = ws;
            fl = ctl & din[0];
            m_irq = m_ien && (mq.size() != 0);
            if (ctl) begin
                m_ien = din[6];
                if (din[4]) m_ovf = 0;
                if (din[5]) m_perr = 0;
            end
            if (fl) mq.delete();
            else if (pop && mq.size() > 0) void'(mq.pop_front());
            if (push) begin
                if (!good) m_perr = 1;
                else if (!fl) begin
                    if (mq.size() < 8) mq.push_back(rx_data);
                    else m_ovf = 1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_dout();
        logic [7:0] r;
        if (addr) r = {mq.size() != 0, m_ien, m_perr, m_ovf, 4'(mq.size())};
        else      r = (mq.size() != 0) ? mq[0] : 8'h00;
        return r;
    endfunction

    // continuous comparison, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("irq", {7'b0, irq}, {7'b0, m_irq});
            if (cs && rd) chk(addr ? "status" : "data", dout, exp_dout());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input bit good);
        rx_data   = b;
        rx_parity = good ? ~^b : ^b;
        rx_done   = 1'b1;
        cyc(6);
        rx_done   = 1'b0;
        cyc(3);
    endtask

    task automatic cpu_rd(input logic a, output logic [7:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        cyc(2);
        @(negedge clk);
        v = dout;
        cyc(1);
        rd = 1'b0; cs = 1'b0;
        cyc(2);
    endtask

    task automatic cpu_wr(input logic a, input logic [7:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; din = v;
        cyc(2);
        wr = 1'b0; cs = 1'b0;
        cyc(1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] v, v2;
        int op;

        // reset with rx_done held high
        cyc(3);
        @(negedge clk);
        chk("reset_dout", dout, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        cyc(1);
        reset = 1'b1;
        chk_en = 1'b1;
        cyc(6);
        cpu_rd(1'b1, v);
        chk("no_push_at_release", v, 8'h00);
        rx_done = 1'b0;
        rx_data = 8'h1C; rx_parity = 1'b0;
        cyc(3);
        rx_done = 1'b1;
        cyc(6);
        rx_done = 1'b0;
        cyc(2);
        cpu_rd(1'b1, v);
        chk("push_after_release", v, 8'h81);
        cpu_wr(1'b1, 8'h01);

        // interrupt path
        cpu_wr(1'b1, 8'h40);
        send(8'h1C, 1'b1);
        chk("irq_on", {7'b0, irq}, 8'h01);
        cpu_rd(1'b1, v);
        chk("stat_c1", v, 8'hC1);
        cpu_rd(1'b0, v);
        chk("data_1c", v, 8'h1C);
        cpu_rd(1'b1, v);
        chk("stat_40", v, 8'h40);
        chk("irq_off", {7'b0, irq}, 8'h00);

        // parity error
        send(8'h1C, 1'b0);
        cpu_rd(1'b1, v);
        chk("stat_perr", v, 8'h60);
        cpu_wr(1'b1, 8'h20);
        cpu_rd(1'b1, v);
        chk("perr_clr", v, 8'h00);

        // overflow
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1);
        cpu_rd(1'b1, v);
        chk("stat_full_ovf", v, 8'h98);
        for (int i = 1; i <= 8; i++) begin
            cpu_rd(1'b0, v);
            chk("ovf_order", v, 8'(i));
        end
        cpu_wr(1'b1, 8'h10);

        // full FIFO: pop and push on the same edge
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b1);
        rx_data = 8'h55; rx_parity = ~^8'h55;
        cs = 1'b1; rd = 1'b1; addr = 1'b0;
        cyc(2);
        rx_done = 1'b1;
        cyc(2);
        rd = 1'b0; cs = 1'b0;
        cyc(4);
        rx_done = 1'b0;
        cyc(2);
        cpu_rd(1'b1, v);
        chk("full_pop_push", v, 8'h88);
        for (int i = 2; i <= 8; i++) begin
            cpu_rd(1'b0, v);
            chk("full_order", v, 8'(i));
        end
        cpu_rd(1'b0, v);
        chk("full_last_55", v, 8'h55);

        // flush coinciding with a push
        cpu_wr(1'b1, 8'h40);
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        rx_data = 8'hA5; rx_parity = ~^8'hA5;
        rx_done = 1'b1;
        cyc(2);
        cs = 1'b1; wr = 1'b1; addr = 1'b1; din = 8'h41;
        cyc(2);
        wr = 1'b0; cs = 1'b0;
        cyc(2);
        rx_done = 1'b0;
        cyc(2);
        cpu_rd(1'b1, v);
        chk("flush_stat", v, 8'h40);
        cpu_rd(1'b0, v);
        chk("flush_data", v, 8'h00);
        chk("flush_irq", {7'b0, irq}, 8'h00);

        // randomized traffic checked by the model
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3: send(8'($urandom), $urandom_range(0, 4) != 0);
                4, 5:       cpu_rd(1'b0, v);
                6:          cpu_rd(1'b1, v);
                7: begin
                    v = 8'($urandom);
                    if ($urandom_range(0, 3) != 0) v[0] = 1'b0;
                    cpu_wr(1'b1, v);
                end
                8: fork
                    send(8'($urandom), 1'b1);
                    begin cyc(int'($urandom_range(0, 4))); cpu_rd(1'b0, v2); end
                join
                default: cpu_wr(1'b0, 8'($urandom));
            endcase
        end

        cyc(2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kbd_rx_fifo.md
# kbd_rx_fifo

Clock-domain bridge and receive buffer between the PS/2 keyboard receiver, clocked by the keyboard's own in_clk, and the Z180 I/O bus in the MIO CPLD. It synchronises the receiver's frame-complete flag into clk and checks odd parity on each received byte. Good scancodes are queued in a small FIFO, and the block presents a two-register CPU interface with a level interrupt, so back-to-back keystrokes are not lost while the CPU is busy.

## Interface
- DEPTH, 8, FIFO entries (power of two).
- AW, 3, log2(DEPTH).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- rx_data  in  8  receiver shift register, LSB first; stable while rx_done is high.
- rx_parity  in  1  received parity bit.
- rx_done  in  1  receiver frame-complete level, asynchronous to clk.
- cs  in  1  chip select, active-high.
- rd  in  1  read strobe, active-high; may span many clk cycles.
- wr  in  1  write strobe, active-high; may span many clk cycles.
- addr  in  1  0 = DATA, 1 = STATUS/CTRL.
- din  in  8  CPU write data.
- dout  out  8  CPU read data, combinational from registered state.
- irq  out  1  interrupt request, active-high, registered.

## Operation
- rx_done passes through a 2-flop synchroniser, followed by a history flop. A push event is sync=1 with history=0.
  - On reset, the synchroniser flops and the history flop all reset to 1. A done level still present at reset release therefore never pushes.
- Parity: odd. The frame is good when ^rx_data ^ rx_parity == 1.
  - Good frame: if count < DEPTH, write rx_data at wptr, then wptr++ and count++.
  - Good frame with count == DEPTH: drop the byte and set OVF.
  - Bad frame: drop the byte and set PERR. OVF is not set for a bad frame.
- DATA read (cs & rd & addr==0):
  - dout = FIFO head while count > 0, else 0x00.
  - Pop happens on the cycle the strobe falls (registered strobe = 1, current = 0). rptr++ and count-- only if count > 0; pop on empty is ignored.
- STATUS read (addr==1), dout fields:
  - [3:0] count.
  - [4] OVF (sticky).
  - [5] PERR (sticky).
  - [6] IEN.
  - [7] NE = (count != 0).
- CTRL write (cs & wr & addr==1) acts once, on the rising edge of the strobe:
  - IEN <= din[6].
  - din[4]=1 clears OVF; din[5]=1 clears PERR.
  - din[0]=1 flushes: pointers and count go to 0.
- Writes to addr 0 are ignored.
- irq <= IEN & NE, registered.
- Simultaneous events:
  - Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, both pointers advance.
  - Push and pop with count == DEPTH: pop first, push accepted, OVF not set.
  - Push and pop with count == 0: pop ignored, push accepted, count = 1.
  - Flush and push in the same cycle: flush wins and the byte is discarded.
  - Flag-clear and a new flag-set in the same cycle: set wins.
- Pointers wrap modulo DEPTH. count is AW+1 bits wide, range 0..DEPTH.
- Reset: pointers, count, OVF, PERR and IEN all 0; irq = 0; dout = 0x00 with addr = 0.

## Timing
- Push latency: the FIFO entry and count update land 3 clk edges after rx_done rises, at the first edge where the value is captured.
- irq asserts 1 cycle after the count update if IEN = 1. It deasserts 1 cycle after the pop that empties the FIFO, or 1 cycle after IEN is cleared.
- The receiver must hold rx_data stable for at least 4 clk cycles after rx_done rises. This is guaranteed for clk ≥ 1 MHz versus the ≥ 60 µs PS/2 bit time.
- dout is valid 1 clk after cs/rd/addr settle. The head changes only after the strobe falls.

## Structure
- Shared package kbd_pkg holds:
  - register addresses ADDR_DATA = 0, ADDR_STAT = 1;
  - status/ctrl bit positions ST_OVF = 4, ST_PERR = 5, ST_IEN = 6, ST_NE = 7, CTL_FLUSH = 0.
- One sub-module, sync2: a 2-flop synchroniser with a reset-value parameter. It is also reused for any future in_clk crossings.
- FIFO storage is an 8×8 register array inside kbd_rx_fifo.

## Test plan
- Reset with rx_done held high, then release -> count = 0, no push, irq = 0; rx_done low→high afterwards -> count = 1.
- IEN = 1; push 0x1C with parity 0 (odd total) -> STATUS = 0xC1, irq = 1; DATA read returns 0x1C; after the strobe falls, STATUS = 0x40 and irq = 0 one cycle later.
- Push 0x1C with parity 1 -> count unchanged, STATUS[5] = 1; CTRL write 0x20 -> PERR cleared.
- Push 9 good bytes 0x01..0x09 without reads -> count = 8, OVF = 1; eight reads return 0x01..0x08 in order.
- FIFO full, with the pop-causing strobe fall aligned to the same cycle as a push of 0x55 -> count stays 8, OVF stays 0, 0x55 is read last.
- Three bytes queued, CTRL write 0x01 coinciding with a push -> count = 0, DATA reads 0x00, irq = 0.
